// File: rtl/mandelbrot_scan.sv
// Viewport scanner: iterates z = z^2 + c over a WIDTH_PX x HEIGHT_PX grid and streams escape counts.
// Optional Julia-set mode is compiled in with `define JULIA_MODE_EN.
module mandelbrot_scan #(
  parameter int BITWIDTH  = 11,
  parameter int CTRWIDTH  = 7,
  parameter int WIDTH_PX  = 4,
  parameter int HEIGHT_PX = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] x0,
  input  logic [BITWIDTH-1:0] y0,
  input  logic [BITWIDTH-1:0] step,
  input  logic [CTRWIDTH-1:0] max_ctr,
`ifdef JULIA_MODE_EN
  input  logic                julia_sel,
  input  logic [BITWIDTH-1:0] jr,
  input  logic [BITWIDTH-1:0] ji,
`endif
  output logic                busy,
  output logic [CTRWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                frame_done
);

  localparam int FRAC = BITWIDTH - 3;
  localparam int PW   = 2 * BITWIDTH;
  localparam int MW   = BITWIDTH + 3;
  localparam int PXW  = (WIDTH_PX  > 1) ? $clog2(WIDTH_PX)  : 1;
  localparam int PYW  = (HEIGHT_PX > 1) ? $clog2(HEIGHT_PX) : 1;
  localparam logic [PXW-1:0] LAST_PX = PXW'(WIDTH_PX - 1);
  localparam logic [PYW-1:0] LAST_PY = PYW'(HEIGHT_PX - 1);
  localparam logic [MW-1:0]  ESC_LIM = MW'(4 << FRAC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                      state_r;
  logic signed [BITWIDTH-1:0]  zr_r, zi_r, pt_x_r, pt_y_r, x0_r, step_r;
  logic [CTRWIDTH-1:0]         ctr_r, max_ctr_r, out_data_r;
  logic [PXW-1:0]              px_r;
  logic [PYW-1:0]              py_r;
  logic                        busy_r, out_valid_r, out_last_r, frame_done_r;

  logic signed [PW-1:0]        sq_r_s, sq_i_s, cross_s, diff_s, dbl_s;
  logic signed [PW:0]          mag_sum_s;
  logic [MW-1:0]               mag_s;
  logic signed [BITWIDTH-1:0]  zr_nxt_s, zi_nxt_s, c_re_s, c_im_s;
  logic signed [BITWIDTH-1:0]  nxt_x_s, nxt_y_s;
  logic [PXW-1:0]              nxt_px_s;
  logic [PYW-1:0]              nxt_py_s;
  logic                        last_pt_s, done_s, jul_s, jul_in_s;

`ifdef JULIA_MODE_EN
  logic                        julia_sel_r;
  logic signed [BITWIDTH-1:0]  jr_r, ji_r;

  // Julia mode and constant are frame-static, captured with the accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      julia_sel_r <= 1'b0;
      jr_r        <= {BITWIDTH{1'b0}};
      ji_r        <= {BITWIDTH{1'b0}};
    end else if ((state_r == S_IDLE) && start && !abort) begin
      julia_sel_r <= julia_sel;
      jr_r        <= $signed(jr);
      ji_r        <= $signed(ji);
    end
  end

  assign jul_s    = julia_sel_r;
  assign jul_in_s = julia_sel;
  assign c_re_s   = julia_sel_r ? jr_r : pt_x_r;
  assign c_im_s   = julia_sel_r ? ji_r : pt_y_r;
`else
  assign jul_s    = 1'b0;
  assign jul_in_s = 1'b0;
  assign c_re_s   = pt_x_r;
  assign c_im_s   = pt_y_r;
`endif

  // Full-precision products; only bits above FRAC survive the wrap to BITWIDTH
  assign sq_r_s    = zr_r * zr_r;
  assign sq_i_s    = zi_r * zi_r;
  assign cross_s   = zr_r * zi_r;
  assign mag_sum_s = {sq_r_s[PW-1], sq_r_s} + {sq_i_s[PW-1], sq_i_s};
  assign mag_s     = MW'(mag_sum_s >>> FRAC);
  assign diff_s    = sq_r_s - sq_i_s;
  assign dbl_s     = cross_s <<< 1;
  assign zr_nxt_s  = BITWIDTH'(diff_s >>> FRAC) + c_re_s;
  assign zi_nxt_s  = BITWIDTH'(dbl_s >>> FRAC) + c_im_s;
  assign done_s    = (mag_s >= ESC_LIM) || (ctr_r == max_ctr_r);

  // Next scan position in row-major order and last-point detection
  always_comb begin
    nxt_px_s  = px_r;
    nxt_py_s  = py_r;
    nxt_x_s   = pt_x_r;
    nxt_y_s   = pt_y_r;
    last_pt_s = 1'b0;
    if (px_r == LAST_PX) begin
      nxt_px_s = {PXW{1'b0}};
      nxt_x_s  = x0_r;
      if (py_r == LAST_PY) begin
        last_pt_s = 1'b1;
      end else begin
        nxt_py_s = py_r + PYW'(1);
        nxt_y_s  = pt_y_r + step_r;
      end
    end else begin
      nxt_px_s = px_r + PXW'(1);
      nxt_x_s  = pt_x_r + step_r;
    end
  end

  // Scan FSM: abort dominates both start and a pending handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      frame_done_r <= 1'b0;
      out_data_r   <= {CTRWIDTH{1'b0}};
      zr_r         <= {BITWIDTH{1'b0}};
      zi_r         <= {BITWIDTH{1'b0}};
      pt_x_r       <= {BITWIDTH{1'b0}};
      pt_y_r       <= {BITWIDTH{1'b0}};
      x0_r         <= {BITWIDTH{1'b0}};
      step_r       <= {BITWIDTH{1'b0}};
      ctr_r        <= {CTRWIDTH{1'b0}};
      max_ctr_r    <= {CTRWIDTH{1'b0}};
      px_r         <= {PXW{1'b0}};
      py_r         <= {PYW{1'b0}};
    end else if (abort) begin
      state_r      <= S_IDLE;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            x0_r      <= $signed(x0);
            step_r    <= $signed(step);
            max_ctr_r <= max_ctr;
            pt_x_r    <= $signed(x0);
            pt_y_r    <= $signed(y0);
            zr_r      <= jul_in_s ? $signed(x0) : {BITWIDTH{1'b0}};
            zi_r      <= jul_in_s ? $signed(y0) : {BITWIDTH{1'b0}};
            ctr_r     <= {CTRWIDTH{1'b0}};
            px_r      <= {PXW{1'b0}};
            py_r      <= {PYW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= S_ITER;
          end
        end
        S_ITER: begin
          if (done_s) begin
            out_data_r  <= ctr_r;
            out_valid_r <= 1'b1;
            out_last_r  <= last_pt_s;
            state_r     <= S_OUT;
          end else begin
            zr_r  <= zr_nxt_s;
            zi_r  <= zi_nxt_s;
            ctr_r <= ctr_r + CTRWIDTH'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (last_pt_s) begin
              frame_done_r <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= S_IDLE;
            end else begin
              px_r    <= nxt_px_s;
              py_r    <= nxt_py_s;
              pt_x_r  <= nxt_x_s;
              pt_y_r  <= nxt_y_s;
              zr_r    <= jul_s ? nxt_x_s : {BITWIDTH{1'b0}};
              zi_r    <= jul_s ? nxt_y_s : {BITWIDTH{1'b0}};
              ctr_r   <= {CTRWIDTH{1'b0}};
              state_r <= S_ITER;
            end
          end
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_mandelbrot_scan.sv
// Randomized self-checking bench for mandelbrot_scan against an arithmetic escape-count model.
module tb_mandelbrot_scan;

  localparam int BW  = 11;
  localparam int CW  = 7;
  localparam int WPX = 4;
  localparam int HPX = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] x0 = '0, y0 = '0, step = '0;
  logic [CW-1:0] max_ctr = '0;
  logic          out_ready = 1'b0;
  logic          busy, out_valid, out_last, frame_done;
  logic [CW-1:0] out_data;
`ifdef JULIA_MODE_EN
  logic          julia_sel = 1'b0;
  logic [BW-1:0] jr = '0, ji = '0;
`endif

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int exp_q[$];
  int jul_v = 0, jr_v = 0, ji_v = 0;

  mandelbrot_scan #(.BITWIDTH(BW), .CTRWIDTH(CW), .WIDTH_PX(WPX), .HEIGHT_PX(HPX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .step(step), .max_ctr(max_ctr),
`ifdef JULIA_MODE_EN
    .julia_sel(julia_sel), .jr(jr), .ji(ji),
`endif
    .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int v);
    logic [BW-1:0] t;
    t = v[BW-1:0];
    return int'($signed(t));
  endfunction

  // Escape count of one point: iterate with floor-division fixed point and BW-bit wrap
  function automatic int ref_count(input int cx, input int cy, input int zx0, input int zy0, input int maxc);
    int zx, zy, nzx, nzy;
    zx = zx0;
    zy = zy0;
    for (int k = 0; k <= maxc; k++) begin
      if ((((zx * zx + zy * zy) >>> 8) >= 1024) || (k == maxc)) return k;
      nzx = wrap(((zx * zx - zy * zy) >>> 8) + cx);
      nzy = wrap(((2 * zx * zy) >>> 8) + cy);
      zx = nzx;
      zy = nzy;
    end
    return maxc;
  endfunction

  task automatic build_exp(input int x0v, input int y0v, input int st, input int mc);
    int px_c, py_c;
    exp_q.delete();
    for (int py = 0; py < HPX; py++) begin
      for (int px = 0; px < WPX; px++) begin
        px_c = wrap(x0v + px * st);
        py_c = wrap(y0v + py * st);
        if (jul_v != 0) exp_q.push_back(ref_count(jr_v, ji_v, px_c, py_c, mc));
        else            exp_q.push_back(ref_count(px_c, py_c, 0, 0, mc));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inputs(input int x0v, input int y0v, input int st, input int mc);
    x0      = x0v[BW-1:0];
    y0      = y0v[BW-1:0];
    step    = st[BW-1:0];
    max_ctr = mc[CW-1:0];
`ifdef JULIA_MODE_EN
    julia_sel = jul_v[0];
    jr        = jr_v[BW-1:0];
    ji        = ji_v[BW-1:0];
`endif
  endtask

  // One full frame: checks data, out_last, per-point latency, hold under backpressure, frame_done
  task automatic run_frame(input int x0v, input int y0v, input int st, input int mc,
                           input int rnd_rdy, input int hold);
    int cyc, idx, guard, holdleft, start_at;
    bit seen, hs, v;
    load_inputs(x0v, y0v, st, mc);
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    x0 = BW'($urandom);
    y0 = BW'($urandom);
    step = BW'($urandom);
    max_ctr = CW'($urandom);
`ifdef JULIA_MODE_EN
    julia_sel = ~julia_sel;
    jr = BW'($urandom);
    ji = BW'($urandom);
`endif
    chk("busy_start", int'(busy), 1);
    cyc = 0; idx = 0; guard = 0; seen = 1'b0;
    holdleft = hold;
    start_at = $urandom_range(1, 8);
    while (idx < exp_q.size() && guard < 20000) begin
      guard++;
      v = out_valid;
      if (v && holdleft > 0) begin
        out_ready = 1'b0;
        holdleft--;
      end else begin
        out_ready = (rnd_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = (guard == start_at);
      if (v) begin
        if (!seen) begin
          chk("latency", cyc, exp_q[idx] + 1);
          seen = 1'b1;
        end
        chk("data", int'(out_data), exp_q[idx]);
        chk("last", int'(out_last), int'(idx == exp_q.size() - 1));
      end
      chk("no_early_done", int'(frame_done), 0);
      hs = v && out_ready;
      tick();
      cyc++;
      start = 1'b0;
      if (hs) begin
        if (idx == exp_q.size() - 1) begin
          chk("frame_done", int'(frame_done), 1);
          chk("busy_end", int'(busy), 0);
          chk("valid_end", int'(out_valid), 0);
          tick();
          chk("done_pulse", int'(frame_done), 0);
        end else begin
          chk("bubble", int'(out_valid), 0);
          cyc = 0;
        end
        idx++;
        seen = 1'b0;
      end
    end
    if (idx < exp_q.size()) chk("frame_timeout", idx, exp_q.size());
    out_ready = 1'b0;
  endtask

  task automatic abort_test();
    int n, g;
    load_inputs(-512, 0, 256, 15);
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0; g = 0;
    while (n < 2 && g < 500) begin
      if (out_valid) n++;
      tick();
      g++;
    end
    chk("abort_reach", n, 2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_last", int'(out_last), 0);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_done", int'(frame_done), 0);
      chk("abort_idle_valid", int'(out_valid), 0);
      tick();
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);
    tick();
    chk("start_abort_idle2", int'(busy), 0);
    out_ready = 1'b0;
  endtask

  task automatic reset_test();
    int g;
    load_inputs(0, 0, 0, 20);
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    g = 0;
    while (!out_valid && g < 100) begin
      tick();
      g++;
    end
    chk("rst_pending_valid", int'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_last", int'(out_last), 0);
    chk("rst_async_data", int'(out_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_stay_idle", int'(busy), 0);
    end
  endtask

  initial begin
    int xv, yv, sv, mv;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_last", int'(out_last), 0);
    chk("reset_done", int'(frame_done), 0);
    chk("reset_data", int'(out_data), 0);

    build_exp(0, 0, 0, 20);
    run_frame(0, 0, 0, 20, 0, 0);

    exp_q = '{1, 15, 15, 2, 1, 3, 15, 2};
    run_frame(-512, 0, 256, 15, 0, 0);

    build_exp(512, 0, 0, 15);
    run_frame(512, 0, 0, 15, 0, 10);

    build_exp(-300, 100, 37, 0);
    run_frame(-300, 100, 37, 0, 1, 0);

    abort_test();

    exp_q = '{1, 15, 15, 2, 1, 3, 15, 2};
    run_frame(-512, 0, 256, 15, 1, 2);

    for (int f = 0; f < 8; f++) begin
      xv = $urandom_range(0, 1023) - 640;
      yv = $urandom_range(0, 600) - 300;
      sv = $urandom_range(0, 120) - 60;
      mv = $urandom_range(0, 40);
      build_exp(xv, yv, sv, mv);
      run_frame(xv, yv, sv, mv, 1, $urandom_range(0, 3));
    end

`ifdef JULIA_MODE_EN
    jul_v = 1; jr_v = 0; ji_v = 0;
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(512, 0, 0, 15, 0, 0);
    for (int f = 0; f < 4; f++) begin
      jr_v = $urandom_range(0, 400) - 200;
      ji_v = $urandom_range(0, 400) - 200;
      xv = $urandom_range(0, 600) - 300;
      yv = $urandom_range(0, 600) - 300;
      sv = $urandom_range(0, 100) - 50;
      mv = $urandom_range(0, 30);
      build_exp(xv, yv, sv, mv);
      run_frame(xv, yv, sv, mv, 1, 0);
    end
    jul_v = 0; jr_v = 0; ji_v = 0;
`endif

    reset_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
